// File: rtl/iol_ctrl_pkg.sv
// Shared types and helpers for the DDR pin-group sequencer.
package iol_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_TURN  = 3'd1,
    ST_TX    = 3'd2,
    ST_RX    = 3'd3,
    ST_DRAIN = 3'd4
  } state_e;

  localparam logic DIR_TX = 1'b0;
  localparam logic DIR_RX = 1'b1;

  // Each beat carries one bit per pad on each clock edge.
  function automatic int beat_width(input int width);
    return 2 * width;
  endfunction

endpackage

// File: rtl/iol_rx_valid_pipe.sv
// Fixed-latency valid pipe that tracks RX beats in flight through the pad input path.
module iol_rx_valid_pipe #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  output logic valid,
  output logic load,
  output logic empty
);
  logic [DEPTH-1:0] stage_r;
  logic [DEPTH-1:0] shift_s;

  // Next contents of the pipe: new beat enters at stage 0.
  always_comb begin
    shift_s[0] = push;
    for (int i = 1; i < DEPTH; i++) begin
      shift_s[i] = stage_r[i-1];
    end
  end

  assign valid = stage_r[DEPTH-1];
  // load marks the edge at which the output stage becomes valid; empty means no beat survives that edge.
  assign load  = shift_s[DEPTH-1];
  assign empty = (shift_s == {DEPTH{1'b0}});

  // Shift register with synchronous flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      stage_r <= {DEPTH{1'b0}};
    end else begin
      stage_r <= shift_s;
    end
  end

endmodule

// File: rtl/iol_ddr_bus_ctrl.sv
// Half-duplex burst sequencer for a group of DDR I/O-logic pads.
// Owns pad direction, inserts turnaround on direction changes and streams beats.
module iol_ddr_bus_ctrl
  import iol_ctrl_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int LEN_W     = 8,
  parameter int TA_CYCLES = 2,
  parameter int IN_LAT    = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_dir,
  input  logic [LEN_W-1:0]   cmd_len,
  input  logic [2*WIDTH-1:0] tx_data,
  input  logic               tx_valid,
  output logic               tx_ready,
  output logic [2*WIDTH-1:0] rx_data,
  output logic               rx_valid,
  output logic               done,
  output logic               busy,
  output logic [WIDTH-1:0]   iol_do0,
  output logic [WIDTH-1:0]   iol_do1,
  output logic               iol_tristate,
  output logic               iol_ce,
  output logic               iol_hold,
  input  logic [WIDTH-1:0]   iol_di0,
  input  logic [WIDTH-1:0]   iol_di1
);
  localparam int BW   = beat_width(WIDTH);
  localparam int TA_W = (TA_CYCLES > 1) ? $clog2(TA_CYCLES) : 1;
  localparam logic [TA_W-1:0] TA_LAST = TA_W'(TA_CYCLES - 1);

  state_e           state_r, next_state_s;
  logic             dir_r, last_dir_r;
  logic [LEN_W-1:0] len_r, beat_cnt_r;
  logic [TA_W-1:0]  ta_cnt_r;
  logic             accept_s, beat_s, push_s, last_beat_s, ta_done_s;
  logic             pipe_load_s, pipe_empty_s;
  logic             tristate_s, ce_s, hold_s, done_s;

  assign accept_s    = cmd_valid & cmd_ready;
  assign last_beat_s = (beat_cnt_r == len_r);
  assign ta_done_s   = (ta_cnt_r == TA_LAST);

  iol_rx_valid_pipe #(.DEPTH(IN_LAT)) u_rx_pipe (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .valid (rx_valid),
    .load  (pipe_load_s),
    .empty (pipe_empty_s)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE:  next_state_s = !accept_s ? ST_IDLE :
                               (cmd_dir != last_dir_r) ? ST_TURN :
                               (cmd_dir == DIR_TX) ? ST_TX : ST_RX;
      ST_TURN:  next_state_s = !ta_done_s ? ST_TURN : (dir_r == DIR_TX) ? ST_TX : ST_RX;
      ST_TX:    next_state_s = (beat_s && last_beat_s) ? ST_IDLE : ST_TX;
      ST_RX:    next_state_s = last_beat_s ? ST_DRAIN : ST_RX;
      ST_DRAIN: next_state_s = pipe_empty_s ? ST_IDLE : ST_DRAIN;
      default:  next_state_s = ST_IDLE;
    endcase
  end

  // Output decode; pad controls are computed for the state being entered so the registers line up with it.
  always_comb begin
    tx_ready   = 1'b0;
    beat_s     = 1'b0;
    push_s     = 1'b0;
    tristate_s = iol_tristate;
    case (state_r)
      ST_TX: begin
        tx_ready = tx_valid;
        beat_s   = tx_valid;
      end
      ST_RX:   push_s = 1'b1;
      default: push_s = 1'b0;
    endcase
    // Pads stay parked in their last direction while idle.
    case (next_state_s)
      ST_TX:                     tristate_s = 1'b0;
      ST_TURN, ST_RX, ST_DRAIN:  tristate_s = 1'b1;
      default:                   tristate_s = iol_tristate;
    endcase
    ce_s   = beat_s | (next_state_s == ST_RX);
    hold_s = (next_state_s != ST_RX);
    done_s = (next_state_s == ST_IDLE) && ((state_r == ST_TX) || (state_r == ST_DRAIN));
  end

  // Command context, counters, data path and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      dir_r        <= DIR_RX;
      last_dir_r   <= DIR_RX;
      len_r        <= {LEN_W{1'b0}};
      beat_cnt_r   <= {LEN_W{1'b0}};
      ta_cnt_r     <= {TA_W{1'b0}};
      iol_do0      <= {WIDTH{1'b0}};
      iol_do1      <= {WIDTH{1'b0}};
      rx_data      <= {BW{1'b0}};
      iol_tristate <= 1'b1;
      iol_ce       <= 1'b0;
      iol_hold     <= 1'b1;
      cmd_ready    <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      if (accept_s) begin
        dir_r      <= cmd_dir;
        len_r      <= cmd_len;
        beat_cnt_r <= {LEN_W{1'b0}};
      end else if (beat_s || push_s) begin
        beat_cnt_r <= beat_cnt_r + LEN_W'(1);
      end
      if (state_r == ST_TURN) begin
        ta_cnt_r <= ta_cnt_r + TA_W'(1);
      end else begin
        ta_cnt_r <= {TA_W{1'b0}};
      end
      if ((state_r == ST_TURN) && ta_done_s) begin
        last_dir_r <= dir_r;
      end
      if (beat_s) begin
        iol_do0 <= tx_data[WIDTH-1:0];
        iol_do1 <= tx_data[BW-1:WIDTH];
      end
      if (pipe_load_s) begin
        rx_data <= {iol_di1, iol_di0};
      end
      iol_tristate <= tristate_s;
      iol_ce       <= ce_s;
      iol_hold     <= hold_s;
      cmd_ready    <= (next_state_s == ST_IDLE);
      busy         <= (next_state_s != ST_IDLE);
      done         <= done_s;
    end
  end

endmodule

// File: tb/tb_iol_ddr_bus_ctrl.sv
// Scoreboard bench for iol_ddr_bus_ctrl: directed scenarios plus randomized bursts,
// with expected pad/fabric traffic computed from burst timing rules.
module tb_iol_ddr_bus_ctrl;
  import iol_ctrl_pkg::*;

  localparam int WIDTH = 4;
  localparam int LEN_W = 8;
  localparam int TA    = 2;
  localparam int LAT   = 2;
  localparam int BW    = 2 * WIDTH;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cmd_valid = 1'b0, cmd_ready, cmd_dir = 1'b0;
  logic [LEN_W-1:0] cmd_len = '0;
  logic [BW-1:0]    tx_data = '0;
  logic             tx_valid = 1'b0, tx_ready;
  logic [BW-1:0]    rx_data;
  logic             rx_valid, done, busy;
  logic [WIDTH-1:0] iol_do0, iol_do1, iol_di0, iol_di1;
  logic             iol_tristate, iol_ce, iol_hold;
  logic [BW-1:0]    di_cur;

  iol_ddr_bus_ctrl #(.WIDTH(WIDTH), .LEN_W(LEN_W), .TA_CYCLES(TA), .IN_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_dir(cmd_dir),
    .cmd_len(cmd_len), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .done(done), .busy(busy),
    .iol_do0(iol_do0), .iol_do1(iol_do1), .iol_tristate(iol_tristate), .iol_ce(iol_ce),
    .iol_hold(iol_hold), .iol_di0(iol_di0), .iol_di1(iol_di1)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Pad input data: a fixed random value per clock cycle, known ahead of time.
  logic [BW-1:0] di_tab [0:1023];
  assign iol_di0 = di_cur[WIDTH-1:0];
  assign iol_di1 = di_cur[BW-1:WIDTH];
  initial begin
    for (int i = 0; i < 1024; i++) di_tab[i] = BW'($urandom());
    di_cur = di_tab[0];
    forever begin
      @(posedge clk);
      #1 di_cur = di_tab[cyc % 1024];
    end
  end

  typedef struct { logic [BW-1:0] data; int cyc; } rx_exp_t;
  rx_exp_t       rx_q[$];
  logic [BW-1:0] tx_q[$];
  int            done_q[$];
  logic [BW-1:0] tx_words[$];
  logic          m_last_dir = DIR_RX;
  int            n_checks = 0;
  int            n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents RX data, a TX pad beat or done.
  always @(negedge clk) begin : mon
    rx_exp_t       e;
    logic [BW-1:0] w;
    int            d;
    if (!rst) begin
      if (rx_valid) begin
        chk("rx_pending", rx_q.size() > 0, 1);
        if (rx_q.size() > 0) begin
          e = rx_q.pop_front();
          chk("rx_data", rx_data, e.data);
          chk("rx_cycle", cyc, e.cyc);
          chk("rx_tristate", iol_tristate, 1);
        end
      end
      if (iol_ce && !iol_tristate) begin
        chk("tx_pending", tx_q.size() > 0, 1);
        if (tx_q.size() > 0) begin
          w = tx_q.pop_front();
          chk("tx_do", {iol_do1, iol_do0}, w);
        end
      end
      if (done) begin
        chk("done_pending", done_q.size() > 0, 1);
        chk("done_busy", busy, 0);
        if (done_q.size() > 0) begin
          d = done_q.pop_front();
          chk("done_cycle", cyc, d);
        end
      end
    end
  end

  // Issue one burst; rst_beat >= 0 asserts reset while that TX beat is being consumed.
  task automatic issue(input logic dir, input int len, input int gap_at, input int gap_len,
                       input bit rand_gap, input int rst_beat);
    int a, e, budget, ng, d;
    bit turn, got;
    logic [BW-1:0] w;
    cmd_valid = 1'b1; cmd_dir = dir; cmd_len = LEN_W'(len);
    budget = 0;
    @(negedge clk);
    while (!cmd_ready && budget < 60) begin
      @(negedge clk);
      budget++;
    end
    chk("cmd_ready", cmd_ready, 1);
    if (!cmd_ready) begin
      cmd_valid = 1'b0;
      return;
    end
    a = cyc;
    turn = (dir != m_last_dir);
    chk("parked_tristate", iol_tristate, m_last_dir == DIR_RX);
    e = a + 1 + (turn ? TA : 0);
    m_last_dir = dir;
    if (dir == DIR_RX) begin
      for (int k = 0; k <= len; k++) rx_q.push_back('{data: di_tab[(e + k + LAT - 1) % 1024], cyc: e + k + LAT});
      done_q.push_back(e + len + LAT + 1);
    end
    @(posedge clk); #1 cmd_valid = 1'b0;
    for (int t = 0; t < TA && turn; t++) begin
      @(negedge clk);
      chk("turn_tristate", iol_tristate, 1);
      chk("turn_ce", iol_ce, 0);
      chk("turn_busy", busy, 1);
      @(posedge clk); #1;
    end
    if (dir == DIR_RX) begin
      @(negedge clk);
      chk("rx_ce", iol_ce, 1);
      chk("rx_hold", iol_hold, 0);
      chk("rx_tristate_entry", iol_tristate, 1);
      d = e + len + LAT + 1;
      while (cyc < d) begin
        @(posedge clk); #1;
      end
      return;
    end
    for (int i = 0; i <= len; i++) begin
      ng = (i == gap_at) ? gap_len : (rand_gap ? int'($urandom_range(0, 2)) : 0);
      tx_valid = 1'b0;
      repeat (ng) begin
        @(posedge clk); #1;
      end
      w = (tx_words.size() > 0) ? tx_words.pop_front() : BW'($urandom());
      tx_valid = 1'b1; tx_data = w;
      budget = 0; got = 1'b0;
      while (!got && budget < 20) begin
        @(negedge clk);
        if (tx_ready) got = 1'b1;
        else begin
          @(posedge clk); #1;
          budget++;
        end
      end
      chk("tx_ready", got, 1);
      if (!got) begin
        tx_valid = 1'b0;
        return;
      end
      if (i == 0 && ng == 0) chk("tx_first_beat_cycle", cyc, e);
      if (i == rst_beat) begin
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; tx_valid = 1'b0;
        rx_q.delete(); tx_q.delete(); done_q.delete();
        m_last_dir = DIR_RX;
        @(negedge clk);
        chk("rst_tristate", iol_tristate, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ce", iol_ce, 0);
        chk("rst_do", {iol_do1, iol_do0}, 0);
        repeat (4) @(posedge clk);
        #1;
        return;
      end
      tx_q.push_back(w);
      if (i == len) done_q.push_back(cyc + 1);
      @(posedge clk); #1;
    end
    tx_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_cmd_ready", cmd_ready, 0);
    chk("reset_busy", busy, 0);
    chk("reset_tristate", iol_tristate, 1);
    chk("reset_ce", iol_ce, 0);
    chk("reset_hold", iol_hold, 1);
    chk("reset_do", {iol_do1, iol_do0}, 0);
    chk("reset_rx", {rx_valid, rx_data}, 0);
    chk("reset_done", done, 0);
    chk("reset_tx_ready", tx_ready, 0);
    @(posedge clk); #1;

    issue(DIR_RX, 3, -1, 0, 1'b0, -1);
    tx_words.push_back(8'h5A); tx_words.push_back(8'hC3);
    issue(DIR_TX, 1, -1, 0, 1'b0, -1);
    issue(DIR_TX, 3, 2, 3, 1'b0, -1);
    issue(DIR_TX, 2, -1, 0, 1'b0, -1);
    issue(DIR_TX, 0, -1, 0, 1'b0, -1);
    issue(DIR_RX, 1, -1, 0, 1'b0, -1);
    issue(DIR_RX, 255, -1, 0, 1'b0, -1);
    issue(DIR_TX, 5, -1, 0, 1'b0, 2);
    issue(DIR_TX, 2, -1, 0, 1'b0, -1);
    for (int n = 0; n < 16; n++) begin
      issue(logic'($urandom_range(0, 1)), int'($urandom_range(0, 9)), -1, 0, 1'b1, -1);
    end
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("rx_q_empty", rx_q.size(), 0);
    chk("tx_q_empty", tx_q.size(), 0);
    chk("done_q_empty", done_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
